// File: rtl/bsg_one_hot_ptr_rotate.sv
// rtl/bsg_one_hot_ptr_rotate.sv - one-hot round-robin priority pointer register
//
// Holds the one-hot position where the next priority scan starts.
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset, pointer returns to bit 0
//   load_i     - load data_i rotated left by one (top bit wraps to bit 0)
//   clear_i    - return pointer to bit 0; takes precedence over load_i
//   data_i     - one-hot value to rotate in (the winner of a grant)
//   ptr_o      - registered one-hot pointer
module bsg_one_hot_ptr_rotate #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] ptr_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_o <= width_p'(1);
    end else if (clear_i) begin
      ptr_o <= width_p'(1);
    end else if (load_i) begin
      // The requester just past the winner gets top priority next time.
      ptr_o <= {data_i[width_p-2:0], data_i[width_p-1]};
    end
  end

endmodule

// File: rtl/bsg_one_hot_rr_scheduler.sv
// rtl/bsg_one_hot_rr_scheduler.sv - round-robin scheduler with one-hot grant and hold quantum
//
// Grants one requester at a time. A grant is held while its request stays
// high. It is revoked after max_hold_p granted cycles when another requester
// is waiting. Every grant ends with one idle gap cycle.
// Ports:
//   clk_i       - clock, rising edge
//   reset_n_i   - asynchronous active-low reset
//   reqs_i      - per-requester request levels
//   ptr_clear_i - synchronous pulse, pointer back to requester 0
//   grants_o    - registered grant, one-hot or zero
//   ptr_o       - registered one-hot priority pointer
//   busy_o      - high while any grant is active
//   preempt_o   - high in the last granted cycle of a quantum-expired grant
module bsg_one_hot_rr_scheduler #(
  parameter int els_p      = 4,
  parameter int max_hold_p = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [els_p-1:0] reqs_i,
  input  logic             ptr_clear_i,
  output logic [els_p-1:0] grants_o,
  output logic [els_p-1:0] ptr_o,
  output logic             busy_o,
  output logic             preempt_o
);

  localparam int cnt_w_lp = $clog2(max_hold_p + 1);

  localparam logic [1:0] state_idle = 2'd0;
  localparam logic [1:0] state_busy = 2'd1;
  localparam logic [1:0] state_gap  = 2'd2;

  logic [1:0]          state_r;
  logic [els_p-1:0]    grants_r;
  logic [cnt_w_lp-1:0] hold_r;

  // Wrap-around priority scan: the upper copy of the doubled request vector
  // covers requesters below the pointer once the lower copy is masked.
  logic [2*els_p-1:0] dbl_reqs;
  logic [2*els_p-1:0] dbl_masked;
  logic [2*els_p-1:0] dbl_first;
  logic [els_p-1:0]   winner;

  assign dbl_reqs   = {reqs_i, reqs_i};
  assign dbl_masked = dbl_reqs & {{els_p{1'b1}}, ~(ptr_o - els_p'(1))};
  assign dbl_first  = dbl_masked & (~dbl_masked + (2*els_p)'(1));
  assign winner     = dbl_first[els_p-1:0] | dbl_first[2*els_p-1:els_p];

  logic any_req;
  logic held;
  logic others;
  logic expired;
  logic issue;

  assign any_req = |reqs_i;
  assign held    = |(grants_r & reqs_i);
  assign others  = |(reqs_i & ~grants_r);
  // hold_r counts completed granted cycles, so the current cycle is the
  // max_hold_p-th once hold_r reaches max_hold_p-1.
  assign expired = (hold_r >= cnt_w_lp'(max_hold_p - 1));
  assign issue   = (state_r != state_busy) && any_req;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= state_idle;
      grants_r <= '0;
      hold_r   <= '0;
    end else begin
      case (state_r)
        state_idle, state_gap: begin
          if (any_req) begin
            state_r  <= state_busy;
            grants_r <= winner;
            hold_r   <= '0;
          end else begin
            state_r  <= state_idle;
            grants_r <= '0;
          end
        end
        state_busy: begin
          if (!held || (others && expired)) begin
            // Release wins over expiry because !held is tested first.
            state_r  <= state_gap;
            grants_r <= '0;
          end else if (hold_r != cnt_w_lp'(max_hold_p)) begin
            hold_r <= hold_r + cnt_w_lp'(1);
          end
        end
        default: begin
          state_r  <= state_idle;
          grants_r <= '0;
        end
      endcase
    end
  end

  bsg_one_hot_ptr_rotate #(
    .width_p(els_p)
  ) ptr_rotate (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (issue),
    .clear_i  (ptr_clear_i),
    .data_i   (winner),
    .ptr_o    (ptr_o)
  );

  assign grants_o  = grants_r;
  assign busy_o    = |grants_r;
  assign preempt_o = (state_r == state_busy) && held && others && expired;

endmodule

// File: tb/tb_bsg_one_hot_rr_scheduler.sv
// tb/tb_bsg_one_hot_rr_scheduler.sv - scoreboard bench for bsg_one_hot_rr_scheduler
module tb_bsg_one_hot_rr_scheduler;

  localparam int ELS  = 4;
  localparam int MAXH = 8;

  logic           clk;
  logic           reset_n;
  logic [ELS-1:0] reqs;
  logic           ptr_clear;
  logic [ELS-1:0] grants;
  logic [ELS-1:0] ptr;
  logic           busy;
  logic           preempt;

  bsg_one_hot_rr_scheduler #(
    .els_p     (ELS),
    .max_hold_p(MAXH)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .reqs_i     (reqs),
    .ptr_clear_i(ptr_clear),
    .grants_o   (grants),
    .ptr_o      (ptr),
    .busy_o     (busy),
    .preempt_o  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ELS-1:0] g;
    logic [ELS-1:0] p;
    logic           b;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state 0 idle, 1 busy, 2 gap; m_cnt = granted cycles
  // including the current one.
  int m_state = 0;
  int m_grant = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_grant = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic step(input logic [ELS-1:0] r, input logic c);
    exp_t e;
    logic pre;
    logic h;
    logic oth;
    int   w;
    @(negedge clk);
    reqs      = r;
    ptr_clear = c;
    #1;
    pre = 1'b0;
    if (m_state == 1) begin
      h   = r[m_grant];
      oth = (r & ~(ELS'(1) << m_grant)) != '0;
      if (!h) begin
        m_state = 2;
        m_grant = -1;
      end else if (m_cnt >= MAXH && oth) begin
        pre     = 1'b1;
        m_state = 2;
        m_grant = -1;
      end else if (m_cnt < MAXH) begin
        m_cnt++;
      end
    end else begin
      w = -1;
      for (int k = 0; k < ELS; k++) begin
        if (w < 0 && r[(m_ptr + k) % ELS]) w = (m_ptr + k) % ELS;
      end
      if (w >= 0) begin
        m_state = 1;
        m_grant = w;
        m_ptr   = (w + 1) % ELS;
        m_cnt   = 1;
      end else begin
        m_state = 0;
        m_grant = -1;
      end
    end
    if (c) m_ptr = 0;
    check_eq("preempt", 32'(preempt), 32'(pre));
    e.g = (m_grant >= 0) ? ELS'(1) << m_grant : '0;
    e.p = ELS'(1) << m_ptr;
    e.b = (m_grant >= 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      e = sb.pop_front();
      check_eq("grants", 32'(grants), 32'(e.g));
      check_eq("ptr", 32'(ptr), 32'(e.p));
      check_eq("busy", 32'(busy), 32'(e.b));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    reqs      = '0;
    ptr_clear = 1'b0;
    model_reset();
    #7;
    check_eq("reset_grants", 32'(grants), 32'h0);
    check_eq("reset_ptr", 32'(ptr), 32'h1);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_preempt", 32'(preempt), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Two steady requesters alternate on quantum expiry.
    for (int i = 0; i < 30; i++) step(4'b0110, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Lone requester keeps its grant; counter saturates, no preemption.
    for (int i = 0; i < 22; i++) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);

    // req0 held, req2 raised on grant cycle 3: preempted on grant cycle 8.
    step(4'b0001, 1'b0);
    for (int i = 0; i < 2; i++) step(4'b0001, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0101, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);

    // req0 drops exactly on grant cycle 8 while req2 waits: release, no preempt.
    step(4'b0001, 1'b0);
    for (int i = 0; i < 2; i++) step(4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0101, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Pointer clear coincides with a grant to requester 2.
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Random traffic with occasional pointer clears.
    for (int i = 0; i < 200; i++) begin
      step(ELS'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset in the middle of a grant.
    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_grants", 32'(grants), 32'h0);
    check_eq("async_ptr", 32'(ptr), 32'h1);
    check_eq("async_busy", 32'(busy), 32'h0);
    check_eq("async_preempt", 32'(preempt), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1000, 1'b0);
    check_eq("post_reset_grant", 32'(grants), 32'h8);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
